seq_restoring_divider: RTL

//  Multi-cycle unsigned 8-bit divider. One shared eight_bit_adder_subtractor, used in subtract mode, performs one restoring-division step per clock.

---
 rtl/seq_restoring_divider_pkg.sv | 15 +
 rtl/eight_bit_adder_subtractor.sv | 23 ++
 rtl/seq_restoring_divider.sv | 107 ++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared constants for the sequential restoring divider and its adder.
package seq_restoring_divider_pkg;

  localparam int DIV_WIDTH  = 8;
  localparam int DIV_STEP_W = 3;

  // Adder opcode: 0 = add, 1 = subtract.
  localparam logic OPC_SUB = 1'b1;

  // FSM encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/eight_bit_adder_subtractor.sv
// Shared 8-bit adder/subtractor. In subtract mode the sum is x - y and
// carry_out is the no-borrow flag (1 when x >= y).
module eight_bit_adder_subtractor (
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  input  logic       i_opcode,
  output logic [7:0] o_sum,
  output logic       o_carry_out
);

  logic [7:0] w_y_eff;
  logic [8:0] w_full;

  // Two's-complement subtract: x + ~y + 1.
  always_comb begin
    w_y_eff = i_opcode ? ~i_y : i_y;
    w_full  = {1'b0, i_x} + {1'b0, w_y_eff} + {8'd0, i_opcode};
  end

  assign o_sum       = w_full[7:0];
  assign o_carry_out = w_full[8];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned divider: one restoring-division step per clock,
// reusing the shared adder in subtract mode.
//
//  state | meaning
//  IDLE  | waiting for start; operands captured on accept
//  BUSY  | one quotient bit per cycle, eight cycles
//  DONE  | result held with out_valid until out_ready
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH  = DIV_WIDTH,
  parameter int STEP_W = DIV_STEP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIDTH - 1);

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_r;
  logic [WIDTH-1:0]  r_d;
  logic [STEP_W-1:0] r_step;
  logic              r_dbz;

  logic [WIDTH-1:0]  w_trial;
  logic              w_msb;
  logic [WIDTH-1:0]  w_sum;
  logic              w_carry;
  logic              w_ok;

  // Shift the next dividend bit into the partial remainder. When the
  // remainder's top bit falls off, the 9-bit value exceeds any divisor,
  // so the 8-bit difference is still exact and the step must succeed.
  always_comb begin
    w_trial = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
    w_msb   = r_r[WIDTH-1];
    w_ok    = w_msb | w_carry;
  end

  eight_bit_adder_subtractor u_addsub (
    .i_x         (w_trial),
    .i_y         (r_d),
    .i_opcode    (OPC_SUB),
    .o_sum       (w_sum),
    .o_carry_out (w_carry)
  );

  // FSM, step counter and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_step  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_q     <= dividend;
            r_d     <= divisor;
            r_r     <= '0;
            r_step  <= '0;
            r_dbz   <= (divisor == '0);
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_r    <= w_ok ? w_sum : w_trial;
          r_q    <= {r_q[WIDTH-2:0], w_ok};
          r_step <= r_step + STEP_W'(1);
          if (r_step == STEP_LAST) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Status and result outputs decode straight from registers.
  always_comb begin
    busy        = (r_state == ST_BUSY) || (r_state == ST_DONE);
    out_valid   = (r_state == ST_DONE);
    quotient    = r_q;
    remainder   = r_r;
    div_by_zero = r_dbz;
  end

endmodule
